game_round_ctrl: RTL
====================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
- REQ-001 Parameter LIVES, default 3: lives granted per game, range 1..7.
- REQ-002 Parameter HOLD_CYCLES, default 100: cycles the WIN/LOSE result is shown before the next action, minimum 1.
- REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
- REQ-004 Port rst, input, 1 bit: asynchronous reset, active-high.
- REQ-005 Port start, input, 1 bit: single-cycle pulse that begins a game; already synchronised and debounced.
- REQ-006 Port submit, input, 1 bit: single-cycle pulse that commits the player's answer; already synchronised and debounced.
- REQ-007 Port answer, input, 8 bits: the player's binary answer from the switches.
- REQ-008 Port time_out, input, 1 bit: level timeout flag from the digit countdown timer.
- REQ-009 Port timer_enable, output, 1 bit: enables the countdown timer.
- REQ-010 Port timer_reconfig, output, 1 bit: one-cycle pulse that reloads the countdown timer.
- REQ-011 Port target, output, 8 bits: the number the player must reproduce.
- REQ-012 Port score_ones, output, 4 bits: BCD ones digit of the score.
- REQ-013 Port score_tens, output, 4 bits: BCD tens digit of the score.
- REQ-014 Port lives_left, output, 3 bits: remaining lives.
- REQ-015 Ports win, lose, game_over, outputs, 1 bit each: status indicators.

Function
- REQ-016 The block SHALL be a state machine with states IDLE, LOAD, PLAY, WIN, LOSE and OVER.
- REQ-017 IDLE SHALL move to LOAD on start; all other inputs SHALL be ignored in IDLE.
- REQ-018 LOAD SHALL last exactly 1 cycle:
  - assert timer_reconfig;
  - register the next target value;
  - move to PLAY.
- REQ-019 In PLAY, timer_enable SHALL be 1; it SHALL be 0 in every other state.
- REQ-020 PLAY transitions SHALL be:
  - time_out=1 -> LOSE;
  - else submit with answer==target -> WIN;
  - else submit with answer!=target -> LOSE.
- REQ-021 If time_out and a correct submit occur in the same cycle, the block SHALL go to LOSE.
- REQ-022 On entry to WIN, the score SHALL increment by 1 in BCD (09->10) and SHALL saturate at 99.
- REQ-023 On entry to LOSE, lives_left SHALL decrement by 1.
- REQ-024 WIN and LOSE SHALL each assert their indicator for exactly HOLD_CYCLES cycles.
  - WIN then moves to LOAD.
  - LOSE then moves to OVER if lives_left==0, else to LOAD.
- REQ-025 In OVER, game_over SHALL be 1; start SHALL clear the score, set lives_left=LIVES and move to LOAD.
- REQ-026 submit and start SHALL have no effect outside the states named above.
- REQ-027 target SHALL change only in LOAD and SHALL never be 0.
- REQ-028 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
- REQ-029 rst SHALL asynchronously force the following, from any state, including mid-round and mid-hold:
  - state=IDLE;
  - timer_enable=0 and timer_reconfig=0;
  - target=8'h01;
  - score=00;
  - lives_left=LIVES;
  - win=0, lose=0 and game_over=0.

Configuration
- REQ-030 Macro GAME_ROUND_LFSR_EN SHALL select how the next target is produced.
  - Defined: the next target comes from an 8-bit maximal-length LFSR (taps 8,6,5,4, seed 8'h01) that steps every clock cycle, so the value depends on the player's timing; an LFSR value of 0 is impossible.
  - Undefined: the next target is the previous target +37 mod 256, with a result of 0 replaced by 1.

Structure
- REQ-031 Package game_pkg SHALL hold the state enumeration, the LFSR seed and taps, the step constant 37 and the BCD maximum of 99.
- REQ-032 Sub-module game_target_gen SHALL contain both target sources (LFSR and step), selected by the macro.
- REQ-033 The block SHALL connect directly to the digit countdown timer: timer_enable drives its enable, timer_reconfig drives its reconfig, and its timeout output drives time_out.

Verification
- REQ-034 Reset then start (LFSR disabled): 1 cycle later timer_reconfig pulses and target=38; the next cycle timer_enable=1.
- REQ-035 In PLAY, submit with answer=target: win is high for 100 cycles and score goes 00->01; then LOAD.
- REQ-036 Score=09, then a win: score_tens=1 and score_ones=0. Score=99, then a win: score stays 99.
- REQ-037 Time_out and a correct submit in the same cycle: lose=1, lives_left 3->2, score unchanged.
- REQ-038 Three wrong submits: after the third hold, game_over=1 and lives_left=0; start then gives score=00, lives_left=3, state LOAD.
- REQ-039 rst asserted in the middle of a WIN hold: all outputs immediately take their reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller.
// GAME_ROUND_LFSR_EN selects the LFSR target source in game_target_gen.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_WIN,
        ST_LOSE,
        ST_OVER
    } state_t;

    // Fibonacci LFSR, taps at bits 8,6,5,4 (1-based) => mask bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED   = 8'h01;
    localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;
    localparam logic [7:0] TARGET_STEP = 8'd37;
    localparam logic [7:0] BCD_MAX     = 8'h99;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/game_target_gen.sv
// Holds the target register and produces its next value on load.
// GAME_ROUND_LFSR_EN defined: free-running LFSR; undefined: previous target + 37, 0 -> 1.
module game_target_gen
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic [7:0] target
);

    logic [7:0] target_q;
    logic [7:0] target_d;
    logic [7:0] next_target;

`ifdef GAME_ROUND_LFSR_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d      = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        next_target = lfsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end
`else
    logic [7:0] stepped;

    always_comb begin
        stepped     = target_q + TARGET_STEP;
        next_target = (stepped == 8'h00) ? 8'h01 : stepped;
    end
`endif

    always_comb begin
        target_d = load ? next_target : target_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            target_q <= 8'h01;
        else
            target_q <= target_d;
    end

    assign target = target_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the number-matching game: target load, play, result hold, game over.
// Target source chosen by GAME_ROUND_LFSR_EN inside game_target_gen.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | one cycle: reload countdown timer, register next target
// PLAY  | timer running, waiting for submit or timeout
// WIN   | correct answer, indicator held HOLD_CYCLES
// LOSE  | wrong answer or timeout, indicator held HOLD_CYCLES
// OVER  | no lives left, waiting for start
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] answer,
    input  logic       time_out,
    output logic       timer_enable,
    output logic       timer_reconfig,
    output logic [7:0] target,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [2:0] lives_left,
    output logic       win,
    output logic       lose,
    output logic       game_over
);

    localparam int              HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]      LIVES_INIT = 3'(LIVES);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]          score_q, score_d;
    logic [2:0]          lives_q, lives_d;
    logic                timer_enable_q, timer_enable_d;
    logic                timer_reconfig_q, timer_reconfig_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;
    logic                game_over_q, game_over_d;
    logic                target_load;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        score_d    = score_q;
        lives_d    = lives_q;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Timeout has priority over a submit arriving in the same cycle
                if (time_out || (submit && (answer != target))) begin
                    state_d    = ST_LOSE;
                    lives_d    = lives_q - 3'd1;
                    hold_cnt_d = HOLD_LOAD;
                end else if (submit) begin
                    state_d    = ST_WIN;
                    score_d    = bcd_inc(score_q);
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_WIN: begin
                if (hold_cnt_q == '0)
                    state_d = ST_LOAD;
                else
                    hold_cnt_d = hold_cnt_q - 1'b1;
            end
            ST_LOSE: begin
                if (hold_cnt_q == '0)
                    state_d = (lives_q == 3'd0) ? ST_OVER : ST_LOAD;
                else
                    hold_cnt_d = hold_cnt_q - 1'b1;
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_LOAD;
                    score_d = 8'h00;
                    lives_d = LIVES_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs registered from the next state so they line up with state_q
        timer_enable_d   = (state_d == ST_PLAY);
        timer_reconfig_d = (state_d == ST_LOAD);
        win_d            = (state_d == ST_WIN);
        lose_d           = (state_d == ST_LOSE);
        game_over_d      = (state_d == ST_OVER);
        target_load      = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            hold_cnt_q       <= '0;
            score_q          <= 8'h00;
            lives_q          <= LIVES_INIT;
            timer_enable_q   <= 1'b0;
            timer_reconfig_q <= 1'b0;
            win_q            <= 1'b0;
            lose_q           <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            score_q          <= score_d;
            lives_q          <= lives_d;
            timer_enable_q   <= timer_enable_d;
            timer_reconfig_q <= timer_reconfig_d;
            win_q            <= win_d;
            lose_q           <= lose_d;
            game_over_q      <= game_over_d;
        end
    end

    game_target_gen u_target_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (target_load),
        .target (target)
    );

    assign timer_enable   = timer_enable_q;
    assign timer_reconfig = timer_reconfig_q;
    assign score_ones     = score_q[3:0];
    assign score_tens     = score_q[7:4];
    assign lives_left     = lives_q;
    assign win            = win_q;
    assign lose           = lose_q;
    assign game_over      = game_over_q;

endmodule
